// File: rtl/nasti_lite_writer_if.sv
// NASTI write port plus lite write port of the writer bridge.
// slave: bridge view; master: environment view.
interface nasti_lite_writer_if #(
  parameter int ID_WIDTH         = 1,
  parameter int ADDR_WIDTH       = 8,
  parameter int NASTI_DATA_WIDTH = 64,
  parameter int LITE_DATA_WIDTH  = 32,
  parameter int USER_WIDTH       = 1
);
  logic [ID_WIDTH-1:0]           nasti_aw_id;
  logic [ADDR_WIDTH-1:0]         nasti_aw_addr;
  logic [7:0]                    nasti_aw_len;
  logic [2:0]                    nasti_aw_size;
  logic [1:0]                    nasti_aw_burst;
  logic                          nasti_aw_lock;
  logic [3:0]                    nasti_aw_cache;
  logic [2:0]                    nasti_aw_prot;
  logic [3:0]                    nasti_aw_qos;
  logic [3:0]                    nasti_aw_region;
  logic [USER_WIDTH-1:0]         nasti_aw_user;
  logic                          nasti_aw_valid;
  logic                          nasti_aw_ready;
  logic [NASTI_DATA_WIDTH-1:0]   nasti_w_data;
  logic [NASTI_DATA_WIDTH/8-1:0] nasti_w_strb;
  logic                          nasti_w_last;
  logic [USER_WIDTH-1:0]         nasti_w_user;
  logic                          nasti_w_valid;
  logic                          nasti_w_ready;
  logic [ID_WIDTH-1:0]           nasti_b_id;
  logic [1:0]                    nasti_b_resp;
  logic [USER_WIDTH-1:0]         nasti_b_user;
  logic                          nasti_b_valid;
  logic                          nasti_b_ready;
  logic [ID_WIDTH-1:0]           lite_aw_id;
  logic [ADDR_WIDTH-1:0]         lite_aw_addr;
  logic [2:0]                    lite_aw_prot;
  logic [3:0]                    lite_aw_qos;
  logic [3:0]                    lite_aw_region;
  logic [USER_WIDTH-1:0]         lite_aw_user;
  logic                          lite_aw_valid;
  logic                          lite_aw_ready;
  logic [LITE_DATA_WIDTH-1:0]    lite_w_data;
  logic [LITE_DATA_WIDTH/8-1:0]  lite_w_strb;
  logic [USER_WIDTH-1:0]         lite_w_user;
  logic                          lite_w_valid;
  logic                          lite_w_ready;
  logic [ID_WIDTH-1:0]           lite_b_id;
  logic [1:0]                    lite_b_resp;
  logic [USER_WIDTH-1:0]         lite_b_user;
  logic                          lite_b_valid;
  logic                          lite_b_ready;

  modport slave (
    input  nasti_aw_id, nasti_aw_addr, nasti_aw_len, nasti_aw_size,
    input  nasti_aw_burst, nasti_aw_lock, nasti_aw_cache, nasti_aw_prot,
    input  nasti_aw_qos, nasti_aw_region, nasti_aw_user, nasti_aw_valid,
    output nasti_aw_ready,
    input  nasti_w_data, nasti_w_strb, nasti_w_last, nasti_w_user,
    input  nasti_w_valid,
    output nasti_w_ready,
    output nasti_b_id, nasti_b_resp, nasti_b_user, nasti_b_valid,
    input  nasti_b_ready,
    output lite_aw_id, lite_aw_addr, lite_aw_prot, lite_aw_qos,
    output lite_aw_region, lite_aw_user, lite_aw_valid,
    input  lite_aw_ready,
    output lite_w_data, lite_w_strb, lite_w_user, lite_w_valid,
    input  lite_w_ready,
    input  lite_b_id, lite_b_resp, lite_b_user, lite_b_valid,
    output lite_b_ready
  );

  modport master (
    output nasti_aw_id, nasti_aw_addr, nasti_aw_len, nasti_aw_size,
    output nasti_aw_burst, nasti_aw_lock, nasti_aw_cache, nasti_aw_prot,
    output nasti_aw_qos, nasti_aw_region, nasti_aw_user, nasti_aw_valid,
    input  nasti_aw_ready,
    output nasti_w_data, nasti_w_strb, nasti_w_last, nasti_w_user,
    output nasti_w_valid,
    input  nasti_w_ready,
    input  nasti_b_id, nasti_b_resp, nasti_b_user, nasti_b_valid,
    output nasti_b_ready,
    input  lite_aw_id, lite_aw_addr, lite_aw_prot, lite_aw_qos,
    input  lite_aw_region, lite_aw_user, lite_aw_valid,
    output lite_aw_ready,
    input  lite_w_data, lite_w_strb, lite_w_user, lite_w_valid,
    output lite_w_ready,
    output lite_b_id, lite_b_resp, lite_b_user, lite_b_valid,
    input  lite_b_ready
  );
endinterface

// File: rtl/nasti_lite_writer.sv
// NASTI write burst -> lite single-word writes, one merged B per burst.
// NASTI_LITE_WRITER_SKIP_EMPTY_EN: skip sub-words with all-zero strobes.
module nasti_lite_writer #(
  parameter int ID_WIDTH         = 1,
  parameter int ADDR_WIDTH       = 8,
  parameter int NASTI_DATA_WIDTH = 64,
  parameter int LITE_DATA_WIDTH  = 32,
  parameter int USER_WIDTH       = 1,
  parameter int MAX_OUTSTANDING  = 2
) (
  input logic                clk,
  input logic                rst,
  nasti_lite_writer_if.slave bus
);
  localparam int LB  = LITE_DATA_WIDTH / 8;
  localparam int LSB = $clog2(LB);
  localparam int NW  = NASTI_DATA_WIDTH / LITE_DATA_WIDTH;
  localparam int IW  = (NW > 1) ? $clog2(NW) : 1;
  localparam int SW  = $clog2(NW) + 1;
  localparam int OW  = $clog2(MAX_OUTSTANDING + 1);

  if (!(LITE_DATA_WIDTH == 32 || LITE_DATA_WIDTH == 64)) begin : g_bad_lite
    $fatal(1, "LITE_DATA_WIDTH must be 32 or 64");
  end
  if (NW < 1 || (NW & (NW - 1)) != 0) begin : g_bad_ratio
    $fatal(1, "NASTI_DATA_WIDTH must be a power-of-2 multiple of LITE_DATA_WIDTH");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_BEAT, S_SPLIT, S_DRAIN, S_RESP
  } state_t;

  state_t                      state_q;
  logic [ID_WIDTH-1:0]         id_q;
  logic [ADDR_WIDTH-1:0]       addr_q;
  logic [7:0]                  cnt_q;
  logic [2:0]                  size_q;
  logic [2:0]                  prot_q;
  logic [3:0]                  qos_q;
  logic [3:0]                  region_q;
  logic [USER_WIDTH-1:0]       auser_q;
  logic [NASTI_DATA_WIDTH-1:0] data_q;
  logic [NW*LB-1:0]            strb_q;
  logic [USER_WIDTH-1:0]       wuser_q;
  logic                        last_q;
  logic [SW-1:0]               sub_q;
  logic                        act_q;
  logic                        aw_v_q;
  logic                        w_v_q;
  logic [OW-1:0]               out_q;
  logic [1:0]                  resp_q;
  logic [USER_WIDTH-1:0]       buser_q;
  logic                        b_v_q;
  logic                        aw_rdy_q;
  logic                        w_rdy_q;

  logic                        aw_hs, w_hs, b_hs;
  logic                        law_hs, lw_hs, lb_hs, lb_rdy;
  logic [OW-1:0]               out_d;
  logic [1:0]                  resp_d;
  logic [IW-1:0]               idx;
  logic [LITE_DATA_WIDTH-1:0]  sub_data;
  logic [LB-1:0]               sub_strb;
  logic                        sub_done, skip, can_issue, beat_end;
  logic [SW-1:0]               p_calc;
  logic                        unused_sig;

  assign aw_hs  = bus.nasti_aw_valid & aw_rdy_q;
  assign w_hs   = bus.nasti_w_valid & w_rdy_q;
  assign b_hs   = b_v_q & bus.nasti_b_ready;
  assign law_hs = aw_v_q & bus.lite_aw_ready;
  assign lw_hs  = w_v_q & bus.lite_w_ready;
  assign lb_rdy = (out_q != '0);
  assign lb_hs  = bus.lite_b_valid & lb_rdy;
  assign out_d  = out_q + OW'(law_hs) - OW'(lb_hs);

  if (NW > 1) begin : g_idx
    assign idx = addr_q[LSB +: IW];
  end else begin : g_idx1
    assign idx = '0;
  end

  assign sub_data = data_q[int'(idx)*LITE_DATA_WIDTH +: LITE_DATA_WIDTH];
  assign sub_strb = strb_q[int'(idx)*LB +: LB];
  assign sub_done = act_q & (~aw_v_q | law_hs) & (~w_v_q | lw_hs);
  assign can_issue = int'(out_d) < MAX_OUTSTANDING;
  assign p_calc = (size_q > 3'(LSB)) ? (SW'(1) << (size_q - 3'(LSB)))
                                     : SW'(1);

`ifdef NASTI_LITE_WRITER_SKIP_EMPTY_EN
  assign skip = (state_q == S_SPLIT) & ~act_q & (sub_strb == '0);
`else
  assign skip = 1'b0;
`endif

  assign beat_end = (state_q == S_SPLIT) & (sub_done | skip)
                  & (sub_q == SW'(1));

  // Merge lite responses; a w_last/len disagreement is at least SLVERR.
  always_comb begin
    resp_d = resp_q;
    if (lb_hs && bus.lite_b_resp > resp_d) resp_d = bus.lite_b_resp;
    if (beat_end && (last_q != (cnt_q == 8'd0)) && resp_d < 2'b10)
      resp_d = 2'b10;
  end

  // Burst FSM: accept AW, take beats, issue sub-words, drain, respond.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      id_q     <= '0;
      addr_q   <= '0;
      cnt_q    <= '0;
      size_q   <= '0;
      prot_q   <= '0;
      qos_q    <= '0;
      region_q <= '0;
      auser_q  <= '0;
      data_q   <= '0;
      strb_q   <= '0;
      wuser_q  <= '0;
      last_q   <= 1'b0;
      sub_q    <= '0;
      act_q    <= 1'b0;
      aw_v_q   <= 1'b0;
      w_v_q    <= 1'b0;
      out_q    <= '0;
      resp_q   <= 2'b00;
      buser_q  <= '0;
      b_v_q    <= 1'b0;
      aw_rdy_q <= 1'b1;
      w_rdy_q  <= 1'b0;
    end else begin
      out_q  <= out_d;
      resp_q <= resp_d;
      if (lb_hs) buser_q <= bus.lite_b_user;
      if (law_hs) aw_v_q <= 1'b0;
      if (lw_hs) w_v_q <= 1'b0;
      unique case (state_q)
        S_IDLE: if (aw_hs) begin
          id_q     <= bus.nasti_aw_id;
          addr_q   <= bus.nasti_aw_addr;
          cnt_q    <= bus.nasti_aw_len;
          size_q   <= bus.nasti_aw_size;
          prot_q   <= bus.nasti_aw_prot;
          qos_q    <= bus.nasti_aw_qos;
          region_q <= bus.nasti_aw_region;
          auser_q  <= bus.nasti_aw_user;
          resp_q   <= 2'b00;
          buser_q  <= '0;
          aw_rdy_q <= 1'b0;
          w_rdy_q  <= 1'b1;
          state_q  <= S_BEAT;
        end
        S_BEAT: if (w_hs) begin
          data_q  <= bus.nasti_w_data;
          strb_q  <= bus.nasti_w_strb;
          wuser_q <= bus.nasti_w_user;
          last_q  <= bus.nasti_w_last;
          sub_q   <= p_calc;
          w_rdy_q <= 1'b0;
          state_q <= S_SPLIT;
        end
        S_SPLIT: begin
          if (!act_q && !skip && can_issue) begin
            aw_v_q <= 1'b1;
            w_v_q  <= 1'b1;
            act_q  <= 1'b1;
          end
          if (sub_done || skip) begin
            act_q  <= 1'b0;
            addr_q <= addr_q + ADDR_WIDTH'(LB);
            sub_q  <= sub_q - SW'(1);
            if (beat_end) begin
              if (cnt_q == 8'd0) begin
                state_q <= S_DRAIN;
              end else begin
                cnt_q   <= cnt_q - 8'd1;
                w_rdy_q <= 1'b1;
                state_q <= S_BEAT;
              end
            end
          end
        end
        S_DRAIN: if (out_d == '0) begin
          b_v_q   <= 1'b1;
          state_q <= S_RESP;
        end
        S_RESP: if (b_hs) begin
          b_v_q    <= 1'b0;
          resp_q   <= 2'b00;
          aw_rdy_q <= 1'b1;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.nasti_aw_ready = aw_rdy_q;
  assign bus.nasti_w_ready  = w_rdy_q;
  assign bus.nasti_b_valid  = b_v_q;
  assign bus.nasti_b_id     = id_q;
  assign bus.nasti_b_resp   = resp_q;
  assign bus.nasti_b_user   = buser_q;
  assign bus.lite_aw_valid  = aw_v_q;
  assign bus.lite_aw_id     = id_q;
  assign bus.lite_aw_addr   = addr_q;
  assign bus.lite_aw_prot   = prot_q;
  assign bus.lite_aw_qos    = qos_q;
  assign bus.lite_aw_region = region_q;
  assign bus.lite_aw_user   = auser_q;
  assign bus.lite_w_valid   = w_v_q;
  assign bus.lite_w_data    = sub_data;
  assign bus.lite_w_strb    = sub_strb;
  assign bus.lite_w_user    = wuser_q;
  assign bus.lite_b_ready   = lb_rdy;

  assign unused_sig = ^{bus.nasti_aw_burst, bus.nasti_aw_lock,
                        bus.nasti_aw_cache, bus.lite_b_id};
endmodule

// File: tb/tb_nasti_lite_writer.sv
// Directed bench for nasti_lite_writer (NASTI 64 / lite 32 / 2 outstanding).
// Lite side is a simple slave model with B gating and error injection.
module tb_nasti_lite_writer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  nasti_lite_writer_if #(
    .ID_WIDTH(1), .ADDR_WIDTH(8), .NASTI_DATA_WIDTH(64),
    .LITE_DATA_WIDTH(32), .USER_WIDTH(1)
  ) bus ();

  nasti_lite_writer #(
    .ID_WIDTH(1), .ADDR_WIDTH(8), .NASTI_DATA_WIDTH(64),
    .LITE_DATA_WIDTH(32), .USER_WIDTH(1), .MAX_OUTSTANDING(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int n_chk = 0;
  int n_pass = 0;

  logic [7:0]  aw_addr_log[$];
  logic        aw_id_log[$];
  logic [31:0] w_data_log[$];
  logic [3:0]  w_strb_log[$];
  int          rise_log[$];
  int          bhs_log[$];

  int   cyc = 0;
  int   test_id = 0;
  int   seen_id = 0;
  int   pend = 0;
  int   bcnt = 0;
  int   slverr_at = -1;
  logic b_en = 1'b1;
  logic aw_stall = 1'b0;
  logic w_slow = 1'b0;
  logic aw_prev = 1'b0;
  logic last_id = 1'b0;

  int aw_base, w_base, rise_base, bhs_base;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Lite slave: decide inputs at negedge, predict handshakes of next posedge.
  always @(negedge clk) begin
    cyc++;
    if (test_id != seen_id) begin
      seen_id = test_id;
      bcnt = 0;
    end
    if (rst) begin
      pend = 0;
      bus.lite_b_valid = 1'b0;
      bus.lite_aw_ready = 1'b0;
      bus.lite_w_ready = 1'b0;
    end else begin
      bus.lite_b_valid = b_en && pend > 0;
      bus.lite_b_resp = (bcnt == slverr_at) ? 2'b10 : 2'b00;
      bus.lite_b_user = bcnt[0];
      bus.lite_b_id = last_id;
      if (bus.lite_b_valid && bus.lite_b_ready) begin
        pend--;
        bcnt++;
        bhs_log.push_back(cyc);
      end
      bus.lite_aw_ready = !aw_stall;
      bus.lite_w_ready = w_slow ? cyc[0] : 1'b1;
      if (bus.lite_aw_valid && bus.lite_aw_ready) begin
        aw_addr_log.push_back(bus.lite_aw_addr);
        aw_id_log.push_back(bus.lite_aw_id);
        last_id = bus.lite_aw_id;
        pend++;
      end
      if (bus.lite_w_valid && bus.lite_w_ready) begin
        w_data_log.push_back(bus.lite_w_data);
        w_strb_log.push_back(bus.lite_w_strb);
      end
    end
    if (bus.lite_aw_valid && !aw_prev) rise_log.push_back(cyc);
    aw_prev = bus.lite_aw_valid;
  end

  task automatic start_test();
    test_id++;
    @(negedge clk);
    @(negedge clk);
    aw_base = aw_addr_log.size();
    w_base = w_data_log.size();
    rise_base = rise_log.size();
    bhs_base = bhs_log.size();
  endtask

  task automatic aw_send(logic [7:0] addr, logic [7:0] len,
                         logic [2:0] size, logic id);
    int k = 0;
    bus.nasti_aw_addr = addr;
    bus.nasti_aw_len = len;
    bus.nasti_aw_size = size;
    bus.nasti_aw_id = id;
    bus.nasti_aw_valid = 1'b1;
    while (!bus.nasti_aw_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("aw_hs", bus.nasti_aw_ready, 1);
    @(negedge clk);
    bus.nasti_aw_valid = 1'b0;
  endtask

  task automatic w_send(logic [63:0] data, logic [7:0] strb, logic last);
    int k = 0;
    bus.nasti_w_data = data;
    bus.nasti_w_strb = strb;
    bus.nasti_w_last = last;
    bus.nasti_w_valid = 1'b1;
    while (!bus.nasti_w_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("w_hs", bus.nasti_w_ready, 1);
    @(negedge clk);
    bus.nasti_w_valid = 1'b0;
  endtask

  task automatic b_expect(string tag, logic id, logic [1:0] resp,
                          logic user);
    int k = 0;
    while (!bus.nasti_b_valid && k < 200) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_bvalid"}, bus.nasti_b_valid, 1);
    check({tag, "_bid"}, bus.nasti_b_id, id);
    check({tag, "_bresp"}, bus.nasti_b_resp, resp);
    check({tag, "_buser"}, bus.nasti_b_user, user);
    bus.nasti_b_ready = 1'b1;
    @(negedge clk);
    bus.nasti_b_ready = 1'b0;
    check({tag, "_one_b"}, bus.nasti_b_valid, 0);
  endtask

  task automatic chk_wr(string tag, int k, logic [7:0] addr,
                        logic [31:0] data, logic [3:0] strb, logic id);
    if (aw_base + k < aw_addr_log.size()) begin
      check({tag, "_addr"}, aw_addr_log[aw_base+k], addr);
      check({tag, "_id"}, aw_id_log[aw_base+k], id);
    end
    if (w_base + k < w_data_log.size()) begin
      check({tag, "_data"}, w_data_log[w_base+k], data);
      check({tag, "_strb"}, w_strb_log[w_base+k], strb);
    end
  endtask

  task automatic chk_cnt(string tag, int n);
    check({tag, "_aw_cnt"}, aw_addr_log.size() - aw_base, n);
    check({tag, "_w_cnt"}, w_data_log.size() - w_base, n);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    bus.nasti_aw_id = '0;
    bus.nasti_aw_addr = '0;
    bus.nasti_aw_len = '0;
    bus.nasti_aw_size = '0;
    bus.nasti_aw_burst = 2'b01;
    bus.nasti_aw_lock = 1'b0;
    bus.nasti_aw_cache = '0;
    bus.nasti_aw_prot = '0;
    bus.nasti_aw_qos = '0;
    bus.nasti_aw_region = '0;
    bus.nasti_aw_user = '0;
    bus.nasti_aw_valid = 1'b0;
    bus.nasti_w_data = '0;
    bus.nasti_w_strb = '0;
    bus.nasti_w_last = 1'b0;
    bus.nasti_w_user = '0;
    bus.nasti_w_valid = 1'b0;
    bus.nasti_b_ready = 1'b0;
    bus.lite_aw_ready = 1'b0;
    bus.lite_w_ready = 1'b0;
    bus.lite_b_valid = 1'b0;
    bus.lite_b_id = '0;
    bus.lite_b_resp = '0;
    bus.lite_b_user = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("rst_aw_ready", bus.nasti_aw_ready, 1);
    check("rst_w_ready", bus.nasti_w_ready, 0);
    check("rst_b_valid", bus.nasti_b_valid, 0);
    check("rst_law_valid", bus.lite_aw_valid, 0);
    check("rst_lw_valid", bus.lite_w_valid, 0);
    check("rst_lb_ready", bus.lite_b_ready, 0);

    // single beat split into two lite words
    start_test();
    aw_send(8'h10, 8'd0, 3'd3, 1'b1);
    w_send(64'h1122334455667788, 8'hFF, 1'b1);
    b_expect("t1", 1'b1, 2'b00, 1'b1);
    chk_cnt("t1", 2);
    chk_wr("t1_w0", 0, 8'h10, 32'h55667788, 4'hF, 1'b1);
    chk_wr("t1_w1", 1, 8'h14, 32'h11223344, 4'hF, 1'b1);

    // two beats, W ready toggling
    start_test();
    w_slow = 1'b1;
    aw_send(8'h10, 8'd1, 3'd3, 1'b0);
    w_send(64'h0000000200000001, 8'hFF, 1'b0);
    w_send(64'h0000000400000003, 8'hFF, 1'b1);
    b_expect("t2", 1'b0, 2'b00, 1'b1);
    w_slow = 1'b0;
    chk_cnt("t2", 4);
    chk_wr("t2_w0", 0, 8'h10, 32'h1, 4'hF, 1'b0);
    chk_wr("t2_w1", 1, 8'h14, 32'h2, 4'hF, 1'b0);
    chk_wr("t2_w2", 2, 8'h18, 32'h3, 4'hF, 1'b0);
    chk_wr("t2_w3", 3, 8'h1C, 32'h4, 4'hF, 1'b0);

    // second lite B is SLVERR
    start_test();
    slverr_at = 1;
    aw_send(8'h10, 8'd1, 3'd3, 1'b1);
    w_send(64'h0000000200000001, 8'hFF, 1'b0);
    w_send(64'h0000000400000003, 8'hFF, 1'b1);
    b_expect("t3", 1'b1, 2'b10, 1'b1);
    slverr_at = -1;

    // outstanding limit with lite B held off
    start_test();
    b_en = 1'b0;
    aw_send(8'h10, 8'd1, 3'd3, 1'b0);
    w_send(64'h0000000200000001, 8'hFF, 1'b0);
    w_send(64'h0000000400000003, 8'hFF, 1'b1);
    repeat (8) @(negedge clk);
    check("t4_stall_aw_cnt", aw_addr_log.size() - aw_base, 2);
    b_en = 1'b1;
    b_expect("t4", 1'b0, 2'b00, 1'b1);
    chk_cnt("t4", 4);
    if (rise_log.size() > rise_base + 2 && bhs_log.size() > bhs_base)
      check("t4_third_aw_cycle", rise_log[rise_base+2],
            bhs_log[bhs_base] + 1);
    else
      check("t4_third_aw_seen", rise_log.size() - rise_base, 4);

    // w_last low on the only beat
    start_test();
    aw_send(8'h20, 8'd0, 3'd3, 1'b0);
    w_send(64'h0000000600000005, 8'hFF, 1'b0);
    b_expect("tlast", 1'b0, 2'b10, 1'b1);
    chk_cnt("tlast", 2);

    // narrow 4-byte beats start in the upper lane
    start_test();
    aw_send(8'h14, 8'd1, 3'd2, 1'b1);
    w_send(64'hAAAAAAAABBBBBBBB, 8'hF0, 1'b0);
    w_send(64'hCCCCCCCCDDDDDDDD, 8'h0F, 1'b1);
    b_expect("tnar", 1'b1, 2'b00, 1'b1);
    chk_cnt("tnar", 2);
    chk_wr("tnar_w0", 0, 8'h14, 32'hAAAAAAAA, 4'hF, 1'b1);
    chk_wr("tnar_w1", 1, 8'h18, 32'hDDDDDDDD, 4'hF, 1'b1);

    // reset while a sub-word is stuck on lite AW
    start_test();
    aw_stall = 1'b1;
    aw_send(8'h40, 8'd0, 3'd3, 1'b1);
    w_send(64'h1, 8'hFF, 1'b1);
    repeat (2) @(negedge clk);
    check("t5_split_aw_valid", bus.lite_aw_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    aw_stall = 1'b0;
    check("t5_aw_ready", bus.nasti_aw_ready, 1);
    check("t5_law_valid", bus.lite_aw_valid, 0);
    check("t5_lw_valid", bus.lite_w_valid, 0);
    check("t5_b_valid", bus.nasti_b_valid, 0);
    check("t5_lb_ready", bus.lite_b_ready, 0);
    start_test();
    aw_send(8'h10, 8'd0, 3'd3, 1'b0);
    w_send(64'h1122334455667788, 8'hFF, 1'b1);
    b_expect("t5b", 1'b0, 2'b00, 1'b1);
    chk_cnt("t5b", 2);
    chk_wr("t5b_w0", 0, 8'h10, 32'h55667788, 4'hF, 1'b0);

    // half-empty strobe
    start_test();
    aw_send(8'h10, 8'd0, 3'd3, 1'b1);
    w_send(64'h1122334455667788, 8'h0F, 1'b1);
`ifdef NASTI_LITE_WRITER_SKIP_EMPTY_EN
    b_expect("t6", 1'b1, 2'b00, 1'b0);
    chk_cnt("t6", 1);
    chk_wr("t6_w0", 0, 8'h10, 32'h55667788, 4'hF, 1'b1);
`else
    b_expect("t6", 1'b1, 2'b00, 1'b1);
    chk_cnt("t6", 2);
    chk_wr("t6_w0", 0, 8'h10, 32'h55667788, 4'hF, 1'b1);
    chk_wr("t6_w1", 1, 8'h14, 32'h11223344, 4'h0, 1'b1);
`endif

    // fully empty strobe
    start_test();
    aw_send(8'h30, 8'd0, 3'd3, 1'b0);
    w_send(64'h0, 8'h00, 1'b1);
`ifdef NASTI_LITE_WRITER_SKIP_EMPTY_EN
    b_expect("t7", 1'b0, 2'b00, 1'b0);
    chk_cnt("t7", 0);
`else
    b_expect("t7", 1'b0, 2'b00, 1'b1);
    chk_cnt("t7", 2);
    chk_wr("t7_w1", 1, 8'h34, 32'h0, 4'h0, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
